alu_control: RTL and testbench

- Main ALU-control decoder for the 64-bit single-cycle RISC-V core.
- Maps the 2-bit main-control ALU op plus instruction funct3/funct7 to a 2-bit ALU operation select: ADD, SUB, AND or OR.
- The primary output is combinational, so the datapath sees it the same cycle.
- A registered copy and a sticky illegal-decode flag are provided for pipeline or debug use. Both are clocked on clk and cleared by rst.

---
 rtl/alu_control_if.sv | 31 +++
 rtl/alu_control.sv | 67 ++++++
 tb/tb_alu_control.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_if.sv
// Decode bus for the ALU-control block: instruction fields in, ALU select and
// status out. The master drives the instruction fields; the slave is the decoder.
interface alu_control_if;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] ctrl_ALU_op;
    logic [1:0] ALU_ctrl;
    logic [1:0] ALU_ctrl_q;
    logic       illegal;
    logic       illegal_seen;

    modport master (
        output funct3,
        output funct7,
        output ctrl_ALU_op,
        input  ALU_ctrl,
        input  ALU_ctrl_q,
        input  illegal,
        input  illegal_seen
    );

    modport slave (
        input  funct3,
        input  funct7,
        input  ctrl_ALU_op,
        output ALU_ctrl,
        output ALU_ctrl_q,
        output illegal,
        output illegal_seen
    );
endinterface

// File: rtl/alu_control.sv
// ALU-control decoder for the 64-bit single-cycle RISC-V core: combinational
// ADD/SUB/AND/OR select plus a registered copy and a sticky illegal-decode flag.
module alu_control (
    input logic          clk,
    input logic          rst,
    alu_control_if.slave bus
);
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_t;

    localparam logic [1:0] OP_MEM    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;

    alu_sel_t   alu_sel;
    logic       illegal_dec;
    logic       seen;
    logic [1:0] sel_q;

    // Every unsupported combination falls back to ADD so no X reaches the datapath.
    always_comb begin
        alu_sel     = ALU_ADD;
        illegal_dec = 1'b0;
        case (bus.ctrl_ALU_op)
            OP_MEM:    alu_sel = ALU_ADD;
            OP_BRANCH: alu_sel = ALU_SUB;
            OP_RTYPE: begin
                case ({bus.funct7, bus.funct3})
                    {7'b0000000, 3'b000}: alu_sel = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_sel = ALU_SUB;
                    {7'b0000000, 3'b111}: alu_sel = ALU_AND;
                    {7'b0000000, 3'b110}: alu_sel = ALU_OR;
                    default: begin
                        alu_sel     = ALU_ADD;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_sel     = ALU_ADD;
                illegal_dec = 1'b1;
            end
        endcase
    end

    // The sticky flag has no clear path other than reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= ALU_ADD;
            seen  <= 1'b0;
        end else begin
            sel_q <= alu_sel;
            if (illegal_dec) begin
                seen <= 1'b1;
            end
        end
    end

    assign bus.ALU_ctrl     = alu_sel;
    assign bus.illegal      = illegal_dec;
    assign bus.ALU_ctrl_q   = sel_q;
    assign bus.illegal_seen = seen;
endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: expected decode and register state are
// queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_alu_control;
    typedef struct {
        string      name;
        logic [1:0] ctrl;
        logic       ill;
    } comb_exp_t;

    typedef struct {
        string      name;
        logic [1:0] ctrl_q;
        logic       seen;
    } reg_exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    comb_exp_t comb_sb[$];
    reg_exp_t  reg_sb[$];

    alu_control_if bus ();

    alu_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written straight from the operation table: {ctrl, illegal}.
    function automatic logic [2:0] model(input logic [1:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic [2:0] r;
        r = 3'b001;
        if (op == 2'b00) r = 3'b000;
        else if (op == 2'b01) r = 3'b010;
        else if (op == 2'b10) begin
            if (f7 == 7'h00 && f3 == 3'd0) r = 3'b000;
            else if (f7 == 7'h20 && f3 == 3'd0) r = 3'b010;
            else if (f7 == 7'h00 && f3 == 3'd7) r = 3'b100;
            else if (f7 == 7'h00 && f3 == 3'd6) r = 3'b110;
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7);
        bus.ctrl_ALU_op = op;
        bus.funct3      = f3;
        bus.funct7      = f7;
    endtask

    task automatic test_reset();
        reg_exp_t e;
        @(negedge clk);
        applyStimulus(2'b11, 3'b000, 7'h00);
        reg_sb.push_back('{"seen_set_by_reserved_op", 2'b00, 1'b1});
        @(posedge clk);
        #1;
        e = reg_sb.pop_front();
        vectors++;
        if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
            miscompares++;
            $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                     e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
        end
        #2;
        rst = 1'b1;
        reg_sb.push_back('{"async_reset_mid_cycle", 2'b00, 1'b0});
        #1;
        e = reg_sb.pop_front();
        vectors++;
        if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
            miscompares++;
            $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                     e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
        end
        reg_sb.push_back('{"reset_wins_over_illegal", 2'b00, 1'b0});
        @(posedge clk);
        #1;
        e = reg_sb.pop_front();
        vectors++;
        if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
            miscompares++;
            $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                     e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Combinational table: one row per decode case, checked without any clock edge.
    task automatic test_decode();
        logic [1:0] ops [12] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00};
        logic [2:0] f3s [12] = '{3'b011, 3'b000, 3'b000, 3'b111, 3'b110, 3'b000,
                                 3'b111, 3'b100, 3'b111, 3'b000, 3'b000, 3'b111};
        logic [6:0] f7s [12] = '{7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00,
                                 7'h20, 7'h00, 7'h20, 7'h00, 7'h01, 7'h7f};
        logic [2:0] exps [12] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b110, 3'b010,
                                  3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
        string names [12] = '{"mem_ignores_funct3", "rtype_add", "rtype_sub",
                              "rtype_and", "rtype_or", "branch_sub",
                              "branch_ignores_funct", "rtype_bad_funct3",
                              "rtype_sub_f7_bad_funct3", "reserved_op",
                              "rtype_bad_funct7", "mem_ignores_funct7"};
        comb_exp_t e;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(ops[i], f3s[i], f7s[i]);
            comb_sb.push_back('{names[i], exps[i][2:1], exps[i][0]});
            #1;
            e = comb_sb.pop_front();
            vectors++;
            if ({bus.ALU_ctrl, bus.illegal} !== {e.ctrl, e.ill}) begin
                miscompares++;
                $display("[TB] FAIL %s: got ctrl=%b illegal=%b, want ctrl=%b illegal=%b",
                         e.name, bus.ALU_ctrl, bus.illegal, e.ctrl, e.ill);
            end
        end
    endtask

    task automatic test_registered();
        logic [1:0] ops [3] = '{2'b10, 2'b11, 2'b01};
        logic [2:0] f3s [3] = '{3'b110, 3'b000, 3'b000};
        logic [1:0] qs  [3] = '{2'b11, 2'b00, 2'b01};
        logic       ss  [3] = '{1'b0, 1'b1, 1'b1};
        string names [3] = '{"q_loads_or", "seen_sets_on_reserved", "seen_sticky_on_legal"};
        reg_exp_t e;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            applyStimulus(ops[i], f3s[i], 7'h00);
            reg_sb.push_back('{names[i], qs[i], ss[i]});
            @(posedge clk);
            #1;
            e = reg_sb.pop_front();
            vectors++;
            if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
                miscompares++;
                $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                         e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
            end
        end
    endtask

    task automatic test_reset_pulse();
        reg_exp_t e;
        #2;
        rst = 1'b1;
        reg_sb.push_back('{"reset_pulse_clears_seen", 2'b00, 1'b0});
        #1;
        e = reg_sb.pop_front();
        vectors++;
        if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
            miscompares++;
            $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                     e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(2'b10, 3'b111, 7'h00);
            reg_sb.push_back('{"legal_after_pulse", 2'b10, 1'b0});
            @(posedge clk);
            #1;
            e = reg_sb.pop_front();
            vectors++;
            if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {e.ctrl_q, e.seen}) begin
                miscompares++;
                $display("[TB] FAIL %s: got q=%b seen=%b, want q=%b seen=%b",
                         e.name, bus.ALU_ctrl_q, bus.illegal_seen, e.ctrl_q, e.seen);
            end
        end
    endtask

    // New inputs every cycle, biased toward the legal R-type funct7 values.
    task automatic test_back_to_back();
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] r;
        logic       seen_m;
        comb_exp_t  ce;
        reg_exp_t   re;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        seen_m = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            if (i < 20 && op == 2'b11) op = 2'b10;
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            applyStimulus(op, f3, f7);
            r = model(op, f3, f7);
            comb_sb.push_back('{"b2b_decode", r[2:1], r[0]});
            #1;
            ce = comb_sb.pop_front();
            vectors++;
            if ({bus.ALU_ctrl, bus.illegal} !== {ce.ctrl, ce.ill}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got ctrl=%b illegal=%b, want ctrl=%b illegal=%b",
                         ce.name, i, bus.ALU_ctrl, bus.illegal, ce.ctrl, ce.ill);
            end
            seen_m = seen_m | r[0];
            reg_sb.push_back('{"b2b_registered", r[2:1], seen_m});
            @(posedge clk);
            #1;
            re = reg_sb.pop_front();
            vectors++;
            if ({bus.ALU_ctrl_q, bus.illegal_seen} !== {re.ctrl_q, re.seen}) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d]: got q=%b seen=%b, want q=%b seen=%b",
                         re.name, i, bus.ALU_ctrl_q, bus.illegal_seen, re.ctrl_q, re.seen);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(2'b00, 3'b000, 7'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_decode();
        test_registered();
        test_reset_pulse();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
